// File: rtl/pll_mdrp_pkg.sv
// Shared definitions for the PLL MDRP initiator.
// Opcodes, FSM states and standard PLL register addresses.
package pll_mdrp_pkg;

    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_ADDR = 2'b11;

    localparam logic [7:0] REG_IDIV  = 8'h00;
    localparam logic [7:0] REG_FBDIV = 8'h01;
    localparam logic [7:0] REG_ODIV0 = 8'h02;
    localparam logic [7:0] REG_MDIV  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RDCAP,
        S_RST_PLL,
        S_WAIT_LOCK,
        S_FIN
    } state_e;

    // Opcode driven during the data phase of a transaction.
    function automatic logic [1:0] data_opc(input logic is_wr);
        return is_wr ? OPC_WR : OPC_RD;
    endfunction

endpackage

// File: rtl/pll_mdrp_master_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock.
// Cleared by the synchronous reset so a stale lock never leaks.
module pll_mdrp_master_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_mdrp_master.sv
// PLL MDRP initiator: address/data cycles on MDCLK,
// optional PLL reset pulse and lock wait after a write.
module pll_mdrp_master
    import pll_mdrp_pkg::*;
#(
    parameter int MDCLK_DIV    = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic       relock,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       timeout,
    output logic       mdclk,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock
);

    localparam int DW = (MDCLK_DIV > 1) ? $clog2(MDCLK_DIV) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          mdclk_q, mdclk_d;
    logic          we_q, we_d;
    logic          relock_q, relock_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          timeout_q, timeout_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic lock_s;
    logic tick;
    logic rise;
    logic fall;
    logic accept;
    logic md_act;

    pll_mdrp_master_sync2 u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign tick   = (div_q == DW'(MDCLK_DIV - 1));
    assign rise   = tick & ~mdclk_q;
    assign fall   = tick & mdclk_q;
    assign accept = req & ~busy;
    assign md_act = (state_q == S_ADDR) || (state_q == S_DATA)
                 || (state_q == S_RDCAP);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            mdclk_q   <= 1'b0;
            we_q      <= 1'b0;
            relock_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            rcnt_q    <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            mdclk_q   <= mdclk_d;
            we_q      <= we_d;
            relock_q  <= relock_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            rcnt_q    <= rcnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // Next state, MDCLK divider, request latch and phase counters.
    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        mdclk_d   = 1'b0;
        we_d      = we_q;
        relock_d  = relock_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        rcnt_d    = '0;
        tcnt_d    = '0;

        if (md_act) begin
            div_d   = tick ? '0 : div_q + DW'(1);
            mdclk_d = tick ? ~mdclk_q : mdclk_q;
        end

        unique case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (accept) begin
                    we_d      = we;
                    relock_d  = relock;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    timeout_d = 1'b0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (fall) state_d = S_DATA;
            end
            S_DATA: begin
                if (fall) begin
                    if (!we_q)         state_d = S_RDCAP;
                    else if (relock_q) state_d = S_RST_PLL;
                    else               state_d = S_FIN;
                end
            end
            S_RDCAP: begin
                if (rise) rdata_d = mdrdo;
                if (fall) state_d = S_FIN;
            end
            S_RST_PLL: begin
                if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
                else rcnt_d = rcnt_q + RW'(1);
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_FIN;
                end else if (tcnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs decoded from the current state.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mdopc     = OPC_NOP;
        mdwdi     = '0;
        pll_reset = 1'b0;
        unique case (state_q)
            S_ADDR: begin
                busy  = 1'b1;
                mdopc = OPC_ADDR;
                mdwdi = addr_q;
            end
            S_DATA: begin
                busy  = 1'b1;
                mdopc = data_opc(we_q);
                mdwdi = we_q ? wdata_q : 8'h00;
            end
            S_RDCAP:     busy = 1'b1;
            S_RST_PLL: begin
                busy      = 1'b1;
                pll_reset = 1'b1;
            end
            S_WAIT_LOCK: busy = 1'b1;
            S_FIN:       done = 1'b1;
            default:     busy = 1'b0;
        endcase
    end

    assign mdclk   = mdclk_q;
    assign mdainc  = 1'b0;
    assign rdata   = rdata_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_pll_mdrp_master.sv
// Directed bench for pll_mdrp_master with MDCLK_DIV=2,
// LOCK_TIMEOUT=100, RST_CYCLES=16.
module tb_pll_mdrp_master;
    import pll_mdrp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic       relock = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       timeout;
    logic       mdclk;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo = '0;
    logic       pll_reset;
    logic       pll_lock = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int req_cyc = 0;
    int fall_cyc = -1;
    int rst_hi = 0;
    int lat;
    logic [7:0] done_rdata;
    logic       done_busy;
    logic [9:0] rises[$];

    pll_mdrp_master #(
        .MDCLK_DIV    (2),
        .LOCK_TIMEOUT (100),
        .RST_CYCLES   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .relock    (relock),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .mdclk     (mdclk),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo),
        .pll_reset (pll_reset),
        .pll_lock  (pll_lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] rz(input int i);
        return (i < rises.size()) ? rises[i] : 10'h3ff;
    endfunction

    function automatic logic [31:0] outs();
        return {8'h00, busy, done, rdata, timeout, mdclk, mdopc,
                mdainc, mdwdi, pll_reset};
    endfunction

    task automatic do_req(input logic w, input logic r,
                          input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        req = 1'b1;
        we = w;
        relock = r;
        addr = a;
        wdata = d;
        req_cyc = cyc;
        rises.delete();
        rst_hi = 0;
        fall_cyc = -1;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Observe the port cycle by cycle until done or the budget runs out.
    task automatic wait_done(input int budget, input int lock_dly,
                             input int poke_at, output int l);
        logic pm;
        logic pr;
        pm = mdclk;
        pr = pll_reset;
        l = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (req) req = 1'b0;
            if (poke_at >= 0 && cyc == req_cyc + poke_at) begin
                req = 1'b1;
                we = 1'b0;
                addr = 8'h77;
            end
            if (mdclk && !pm) rises.push_back({mdopc, mdwdi});
            pm = mdclk;
            if (pll_reset) rst_hi++;
            if (pr && !pll_reset) fall_cyc = cyc;
            pr = pll_reset;
            if (fall_cyc >= 0 && lock_dly >= 0
                && cyc == fall_cyc + lock_dly) pll_lock = 1'b1;
            if (done) begin
                l = cyc - req_cyc;
                done_rdata = rdata;
                done_busy = busy;
                break;
            end
        end
    endtask

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: plain write
        do_req(1'b1, 1'b0, 8'h12, 8'h5a);
        @(negedge clk);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        wait_done(40, -1, -1, lat);
        chk("t1_lat", lat, 9);
        chk("t1_busy_at_done", {31'b0, done_busy}, 32'd0);
        chk("t1_nrise", rises.size(), 2);
        chk("t1_rise0", {22'b0, rz(0)}, {22'b0, 2'b11, 8'h12});
        chk("t1_rise1", {22'b0, rz(1)}, {22'b0, 2'b01, 8'h5a});
        chk("t1_prst", rst_hi, 0);
        @(negedge clk);
        chk("t1_done_1cyc", {31'b0, done}, 32'd0);

        // 2: read, then rdata must survive a write
        mdrdo = 8'hc3;
        do_req(1'b0, 1'b0, 8'h20, 8'h99);
        wait_done(40, -1, -1, lat);
        chk("t2_lat", lat, 13);
        chk("t2_rdata", done_rdata, 8'hc3);
        chk("t2_nrise", rises.size(), 3);
        chk("t2_rise0", {22'b0, rz(0)}, {22'b0, 2'b11, 8'h20});
        chk("t2_rise1", {22'b0, rz(1)}, {22'b0, 2'b10, 8'h00});
        chk("t2_rise2", {22'b0, rz(2)}, {22'b0, 2'b00, 8'h00});
        mdrdo = 8'h3c;
        do_req(1'b1, 1'b0, REG_FBDIV, 8'h28);
        wait_done(40, -1, -1, lat);
        chk("t2_wr_lat", lat, 9);
        chk("t2_rdata_hold", rdata, 8'hc3);

        // 3: relock, lock arrives 50 cycles after reset release
        do_req(1'b1, 1'b1, REG_IDIV, 8'h01);
        wait_done(300, 50, -1, lat);
        chk("t3_prst_len", rst_hi, 16);
        chk("t3_done_after_fall", req_cyc + lat - fall_cyc, 53);
        chk("t3_timeout", {31'b0, timeout}, 32'd0);
        pll_lock = 1'b0;
        repeat (4) @(posedge clk);

        // 4: relock with no lock -> timeout
        do_req(1'b1, 1'b1, REG_MDIV, 8'h04);
        wait_done(400, -1, -1, lat);
        chk("t4_prst_len", rst_hi, 16);
        chk("t4_done_after_fall", req_cyc + lat - fall_cyc, 100);
        chk("t4_timeout", {31'b0, timeout}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_timeout_sticky", {31'b0, timeout}, 32'd1);
        do_req(1'b1, 1'b0, REG_ODIV0, 8'h02);
        @(negedge clk);
        chk("t4_timeout_clr", {31'b0, timeout}, 32'd0);
        wait_done(40, -1, -1, lat);
        chk("t4_next_lat", lat, 9);

        // 5: req while busy is ignored
        do_req(1'b1, 1'b0, 8'h33, 8'h44);
        wait_done(40, -1, 4, lat);
        chk("t5_lat", lat, 9);
        chk("t5_nrise", rises.size(), 2);
        chk("t5_rise0", {22'b0, rz(0)}, {22'b0, 2'b11, 8'h33});
        chk("t5_rise1", {22'b0, rz(1)}, {22'b0, 2'b01, 8'h44});
        rises.delete();
        wait_done(20, -1, -1, lat);
        chk("t5_no_second", lat, -1);
        chk("t5_quiet", rises.size(), 0);

        // 6a: reset during DATA
        do_req(1'b1, 1'b0, 8'h55, 8'haa);
        for (int k = 0; k < 20 && cyc < req_cyc + 6; k++)
            @(negedge clk);
        chk("t6_in_data", {30'b0, mdopc}, {30'b0, OPC_WR});
        reset = 1'b1;
        @(negedge clk);
        chk("t6_data_rst", outs(), 32'h0);
        reset = 1'b0;

        // 6b: reset during RST_PLL
        do_req(1'b1, 1'b1, 8'h66, 8'hbb);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (pll_reset) seen = 1'b1;
        end
        chk("t6_prst_seen", {31'b0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_prst_rst", outs(), 32'h0);
        reset = 1'b0;

        do_req(1'b1, 1'b0, 8'h77, 8'hcc);
        wait_done(40, -1, -1, lat);
        chk("t6_after_lat", lat, 9);
        chk("t6_after_rise0", {22'b0, rz(0)}, {22'b0, 2'b11, 8'h77});
        chk("t6_after_rise1", {22'b0, rz(1)}, {22'b0, 2'b01, 8'hcc});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
